// File: rtl/cg_ctrl_pkg.sv
// rtl/cg_ctrl_pkg.sv - shared state encoding, channel indices and per-phase access masks for the CG sequencer
package cg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MXV    = 3'd1,
    ST_DOT    = 3'd2,
    ST_UPD_XR = 3'd3,
    ST_UPD_P  = 3'd4,
    ST_HALT   = 3'd5
  } cg_state_e;

  localparam int CH_X       = 0;
  localparam int CH_R       = 1;
  localparam int CH_P       = 2;
  localparam int CH_AP      = 3;
  localparam int NUM_VEC_CH = 4;

  // Channel masks are {AP,P,R,X}, bit index == channel index.
  localparam logic [NUM_VEC_CH-1:0] RD_MASK_MXV    = 4'b0100;
  localparam logic [NUM_VEC_CH-1:0] RD_MASK_DOT    = 4'b1110;
  localparam logic [NUM_VEC_CH-1:0] RD_MASK_UPD_XR = 4'b1111;
  localparam logic [NUM_VEC_CH-1:0] RD_MASK_UPD_P  = 4'b0110;

  localparam logic [NUM_VEC_CH-1:0] WR_MASK_MXV    = 4'b1000;
  localparam logic [NUM_VEC_CH-1:0] WR_MASK_UPD_XR = 4'b0011;
  localparam logic [NUM_VEC_CH-1:0] WR_MASK_UPD_P  = 4'b0100;

  function automatic logic [NUM_VEC_CH-1:0] rd_mask(input cg_state_e st);
    case (st)
      ST_MXV:    return RD_MASK_MXV;
      ST_DOT:    return RD_MASK_DOT;
      ST_UPD_XR: return RD_MASK_UPD_XR;
      ST_UPD_P:  return RD_MASK_UPD_P;
      default:   return '0;
    endcase
  endfunction

  function automatic logic [NUM_VEC_CH-1:0] wr_mask(input cg_state_e st);
    case (st)
      ST_MXV:    return WR_MASK_MXV;
      ST_UPD_XR: return WR_MASK_UPD_XR;
      ST_UPD_P:  return WR_MASK_UPD_P;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/cg_addr_counter.sv
// rtl/cg_addr_counter.sv - clearable saturating address counter with limit-reached flag
module cg_addr_counter #(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] limit,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  done
);

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  assign addr = cnt_q;
  assign done = (cnt_q >= limit);

  // Clear wins over increment; the count never runs past the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !done) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cg_phase_sequencer.sv
// rtl/cg_phase_sequencer.sv - CG iteration phase FSM and memory address generator (option: CG_CYCLE_COUNT_EN)
module cg_phase_sequencer
  import cg_ctrl_pkg::*;
#(
  parameter int NO_OF_UNITS    = 8,
  parameter int ADDR_WIDTH     = 20,
  parameter int NUM_CLUSTERS   = 40,
  parameter int EQ_PER_CLUSTER = 19,
  parameter int MAX_ITER       = 20,
  parameter int ITER_WIDTH     = 11
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stall,
  input  logic                             scalar_done,
  input  logic                             converged,
  input  logic [NUM_VEC_CH-1:0]            wr_strobe,
  output logic                             a_rd_en,
  output logic [ADDR_WIDTH-1:0]            a_rd_addr,
  output logic [NUM_VEC_CH-1:0]            vec_rd_en,
  output logic [NUM_VEC_CH*ADDR_WIDTH-1:0] vec_rd_addr,
  output logic [NUM_VEC_CH-1:0]            vec_wr_en,
  output logic [NUM_VEC_CH*ADDR_WIDTH-1:0] vec_wr_addr,
  output logic [2:0]                       phase,
  output logic [ITER_WIDTH-1:0]            iteration,
  output logic                             busy,
  output logic                             halt,
  output logic                             seq_err
`ifdef CG_CYCLE_COUNT_EN
  ,
  output logic [31:0]                      cycle_count
`endif
);

  localparam int VEC_WORDS = (EQ_PER_CLUSTER + NO_OF_UNITS - 1) / NO_OF_UNITS;
  localparam logic [ADDR_WIDTH-1:0] VEC_LIM  = ADDR_WIDTH'(VEC_WORDS);
  localparam logic [ADDR_WIDTH-1:0] VEC_LAST = ADDR_WIDTH'(VEC_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] A_LIM    = ADDR_WIDTH'(NUM_CLUSTERS);
  localparam logic [ITER_WIDTH-1:0] ITER_MAX = ITER_WIDTH'(MAX_ITER);

  cg_state_e             state_q, state_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic                  halt_q, halt_d;
  logic                  conv_q, conv_d;
  logic                  scal_seen_q, scal_seen_d;
  logic                  seq_err_q, seq_err_d;
  logic                  phase_entry;
  logic                  start_accept;
  logic                  scal_now;
  logic                  vec_reads_done;

  logic [NUM_VEC_CH-1:0] rd_mask_w, wr_mask_w;
  logic [NUM_VEC_CH-1:0] vr_issue, vr_done;
  logic [NUM_VEC_CH-1:0] wr_ok, wr_bad, wr_done, wr_done_eff;
  logic [NUM_VEC_CH-1:0][ADDR_WIDTH-1:0] vr_cnt, wr_cnt;
  logic                  a_issue, a_done;
  logic [ADDR_WIDTH-1:0] a_cnt;

  logic                                  a_rd_en_q;
  logic [ADDR_WIDTH-1:0]                 a_rd_addr_q;
  logic [NUM_VEC_CH-1:0]                 vec_rd_en_q;
  logic [NUM_VEC_CH-1:0][ADDR_WIDTH-1:0] vec_rd_addr_q;

  // ---------------------------------------------------------------- counters
  cg_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_a_rd (
    .clk   (clk),
    .reset (reset),
    .clear (phase_entry),
    .inc   (a_issue),
    .limit (A_LIM),
    .addr  (a_cnt),
    .done  (a_done)
  );

  for (genvar c = 0; c < NUM_VEC_CH; c++) begin : g_ch
    cg_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd (
      .clk   (clk),
      .reset (reset),
      .clear (phase_entry),
      .inc   (vr_issue[c]),
      .limit (VEC_LIM),
      .addr  (vr_cnt[c]),
      .done  (vr_done[c])
    );

    cg_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr (
      .clk   (clk),
      .reset (reset),
      .clear (phase_entry),
      .inc   (wr_ok[c]),
      .limit (VEC_LIM),
      .addr  (wr_cnt[c]),
      .done  (wr_done[c])
    );
  end

  // Read issue and write legality for the current phase; a final strobe counts toward exit in its own cycle.
  always_comb begin
    rd_mask_w      = rd_mask(state_q);
    wr_mask_w      = wr_mask(state_q);
    vr_issue       = rd_mask_w & ~vr_done & {NUM_VEC_CH{~stall}};
    a_issue        = (state_q == ST_MXV) && !a_done && !stall;
    wr_ok          = wr_strobe & wr_mask_w & ~wr_done;
    wr_bad         = wr_strobe & ~(wr_mask_w & ~wr_done);
    vec_reads_done = &(vr_done | ~rd_mask_w);
    wr_done_eff    = '0;
    for (int c = 0; c < NUM_VEC_CH; c++) begin
      wr_done_eff[c] = wr_done[c] || (wr_ok[c] && (wr_cnt[c] == VEC_LAST));
    end
  end

  // ---------------------------------------------------------------- FSM
  // Next phase, iteration bookkeeping and convergence sampling.
  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    halt_d       = halt_q;
    conv_d       = conv_q;
    start_accept = 1'b0;
    scal_now     = scal_seen_q || scalar_done;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = ST_MXV;
          iter_d       = '0;
          halt_d       = 1'b0;
          conv_d       = 1'b0;
        end
      end
      ST_MXV: begin
        if (a_done && wr_done_eff[CH_AP]) state_d = ST_DOT;
      end
      ST_DOT: begin
        if (vec_reads_done && scal_now) state_d = ST_UPD_XR;
      end
      ST_UPD_XR: begin
        if (scalar_done) conv_d = converged;
        if (wr_done_eff[CH_X] && wr_done_eff[CH_R] && scal_now) state_d = ST_UPD_P;
      end
      ST_UPD_P: begin
        if (wr_done_eff[CH_P]) begin
          iter_d = iter_q + ITER_WIDTH'(1);
          if (conv_q || (iter_d == ITER_MAX)) begin
            state_d = ST_HALT;
            halt_d  = 1'b1;
          end else begin
            state_d = ST_MXV;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase-entry strobe, scalar-ready latch and sticky write-protocol error.
  always_comb begin
    phase_entry = (state_d != state_q);
    scal_seen_d = scal_seen_q;
    if (phase_entry) begin
      scal_seen_d = 1'b0;
    end else if (scalar_done && (state_q == ST_DOT || state_q == ST_UPD_XR)) begin
      scal_seen_d = 1'b1;
    end
    seq_err_d = seq_err_q | (|wr_bad);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      iter_q      <= '0;
      halt_q      <= 1'b0;
      conv_q      <= 1'b0;
      scal_seen_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      halt_q      <= halt_d;
      conv_q      <= conv_d;
      scal_seen_q <= scal_seen_d;
      seq_err_q   <= seq_err_d;
    end
  end

  // Read outputs: enable and the address it qualifies leave the block in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd_en_q     <= 1'b0;
      a_rd_addr_q   <= '0;
      vec_rd_en_q   <= '0;
      vec_rd_addr_q <= '0;
    end else begin
      a_rd_en_q     <= a_issue;
      a_rd_addr_q   <= a_cnt;
      vec_rd_en_q   <= vr_issue;
      vec_rd_addr_q <= vr_cnt;
    end
  end

`ifdef CG_CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  // Busy-cycle counter, restarted by every accepted start and frozen outside busy phases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
    end else if (start_accept) begin
      cyc_q <= '0;
    end else if (busy) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`endif

  assign a_rd_en     = a_rd_en_q;
  assign a_rd_addr   = a_rd_addr_q;
  assign vec_rd_en   = vec_rd_en_q;
  assign vec_rd_addr = vec_rd_addr_q;
  assign vec_wr_en   = wr_ok;
  assign vec_wr_addr = wr_cnt;
  assign phase       = state_q;
  assign iteration   = iter_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halt        = halt_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_cg_phase_sequencer.sv
// tb/tb_cg_phase_sequencer.sv - directed self-checking bench for cg_phase_sequencer
module tb_cg_phase_sequencer;

  localparam int AW = 20;
  localparam int IW = 11;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            stall;
  logic            scalar_done;
  logic            converged;
  logic [3:0]      wr_strobe;
  logic            a_rd_en;
  logic [AW-1:0]   a_rd_addr;
  logic [3:0]      vec_rd_en;
  logic [4*AW-1:0] vec_rd_addr;
  logic [3:0]      vec_wr_en;
  logic [4*AW-1:0] vec_wr_addr;
  logic [2:0]      phase;
  logic [IW-1:0]   iteration;
  logic            busy;
  logic            halt;
  logic            seq_err;
`ifdef CG_CYCLE_COUNT_EN
  logic [31:0]     cycle_count;
  int              busy_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] prev_ph, iss_ph;
  int  rd_a, rd_v[4];
  int  a_gap, a_gap_max, exp_gap;
  bit  mon_en;
  int  exp_iter;
  bit  exp_seq_err;

  always #5 clk = ~clk;

  cg_phase_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .scalar_done (scalar_done),
    .converged   (converged),
    .wr_strobe   (wr_strobe),
    .a_rd_en     (a_rd_en),
    .a_rd_addr   (a_rd_addr),
    .vec_rd_en   (vec_rd_en),
    .vec_rd_addr (vec_rd_addr),
    .vec_wr_en   (vec_wr_en),
    .vec_wr_addr (vec_wr_addr),
    .phase       (phase),
    .iteration   (iteration),
    .busy        (busy),
    .halt        (halt),
    .seq_err     (seq_err)
`ifdef CG_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
    n_cmp++;
    assert (obs === exp_val) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_val);
    end
  endtask

  task automatic mon_clear();
    prev_ph   = 3'd0;
    iss_ph    = 3'd0;
    rd_a      = 0;
    rd_v      = '{0, 0, 0, 0};
    a_gap     = 0;
    a_gap_max = 0;
  endtask

  task automatic close_phase(input logic [2:0] p);
    int         ea;
    logic [3:0] m;
    case (p)
      3'd1:    begin ea = 40; m = 4'b0100; end
      3'd2:    begin ea = 0;  m = 4'b1110; end
      3'd3:    begin ea = 0;  m = 4'b1111; end
      3'd4:    begin ea = 0;  m = 4'b0110; end
      default: begin ea = 0;  m = 4'b0000; end
    endcase
    chk("a_read_count", rd_a, ea);
    for (int c = 0; c < 4; c++) chk("vec_read_count", rd_v[c], m[c] ? 3 : 0);
    if (p == 3'd1) chk("a_stall_gap", a_gap_max, exp_gap);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (prev_ph != iss_ph) begin
        close_phase(iss_ph);
        iss_ph    = prev_ph;
        rd_a      = 0;
        rd_v      = '{0, 0, 0, 0};
        a_gap     = 0;
        a_gap_max = 0;
      end
      if (a_rd_en) begin
        chk("a_rd_addr", a_rd_addr, rd_a);
        rd_a++;
        a_gap = 0;
      end else if (rd_a > 0 && rd_a < 40) begin
        a_gap++;
        if (a_gap > a_gap_max) a_gap_max = a_gap;
      end
      for (int c = 0; c < 4; c++) begin
        if (vec_rd_en[c]) begin
          chk("vec_rd_addr", vec_rd_addr[c*AW +: AW], rd_v[c]);
          rd_v[c]++;
        end
      end
    end
    prev_ph = phase;
`ifdef CG_CYCLE_COUNT_EN
    if (busy) busy_cnt++;
`endif
  endtask

  task automatic do_start();
`ifdef CG_CYCLE_COUNT_EN
    busy_cnt = 0;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_iter = 0;
    chk("start_phase", phase, 3'd1);
    chk("start_iter", iteration, 0);
    chk("start_halt", halt, 1'b0);
    chk("start_busy", busy, 1'b1);
  endtask

  task automatic do_mxv(input bit do_stall, input bit do_err);
    int n;
    exp_gap = do_stall ? 2 : 0;
    n = 0;
    while (phase == 3'd1 && n < 200) begin
      wr_strobe = (n < 3) ? 4'b1000 : 4'b0000;
      if (do_err && n == 3) wr_strobe = 4'b0100;
      if (do_err && n == 4) wr_strobe = 4'b1000;
      stall = do_stall && (n == 5 || n == 6);
      #1;
      if (n < 3) begin
        chk("mxv_wr_en", vec_wr_en, 4'b1000);
        chk("mxv_wr_addr_ap", vec_wr_addr[3*AW +: AW], n);
      end else if (do_err && (n == 3 || n == 4)) begin
        chk("illegal_wr_en", vec_wr_en, 4'b0000);
      end
      tick();
      n++;
    end
    wr_strobe = 4'b0000;
    stall     = 1'b0;
    if (do_err) exp_seq_err = 1'b1;
    chk("mxv_cycles", n, do_stall ? 43 : 41);
    chk("seq_err", seq_err, exp_seq_err);
    chk("dot_phase", phase, 3'd2);
  endtask

  task automatic do_dot();
    int n;
    n = 0;
    while (phase == 3'd2 && n < 50) begin
      scalar_done = (n == 0);
      start       = (n == 1);
      tick();
      n++;
    end
    scalar_done = 1'b0;
    start       = 1'b0;
    chk("dot_cycles", n, 4);
    chk("xr_phase", phase, 3'd3);
  endtask

  task automatic do_xr(input bit conv_now);
    int n;
    n = 0;
    while (phase == 3'd3 && n < 50) begin
      wr_strobe   = (n < 3) ? 4'b0011 : 4'b0000;
      scalar_done = (n == 2);
      converged   = conv_now && (n == 2);
      #1;
      if (n < 3) begin
        chk("xr_wr_en", vec_wr_en, 4'b0011);
        chk("xr_wr_addr_x", vec_wr_addr[0 +: AW], n);
        chk("xr_wr_addr_r", vec_wr_addr[AW +: AW], n);
      end
      tick();
      n++;
    end
    wr_strobe   = 4'b0000;
    scalar_done = 1'b0;
    converged   = 1'b0;
    chk("xr_cycles", n, 3);
    chk("p_phase", phase, 3'd4);
  endtask

  task automatic do_p();
    int n;
    n = 0;
    while (phase == 3'd4 && n < 50) begin
      wr_strobe = (n < 3) ? 4'b0100 : 4'b0000;
      #1;
      if (n < 3) begin
        chk("p_wr_en", vec_wr_en, 4'b0100);
        chk("p_wr_addr", vec_wr_addr[2*AW +: AW], n);
      end
      tick();
      n++;
    end
    wr_strobe = 4'b0000;
    chk("p_cycles", n, 3);
  endtask

  task automatic run_iter(input bit conv_now, input bit do_stall);
    do_mxv(do_stall, 1'b0);
    do_dot();
    do_xr(conv_now);
    do_p();
    exp_iter++;
    chk("iteration", iteration, exp_iter);
    if (conv_now || exp_iter == 20) begin
      chk("halt_phase", phase, 3'd5);
      chk("halt_flag", halt, 1'b1);
      chk("halt_busy", busy, 1'b0);
    end else begin
      chk("next_phase", phase, 3'd1);
      chk("run_halt", halt, 1'b0);
      chk("run_busy", busy, 1'b1);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    stall       = 1'b0;
    scalar_done = 1'b0;
    converged   = 1'b0;
    wr_strobe   = 4'b0000;
    mon_en      = 1'b0;
    exp_iter    = 0;
    exp_seq_err = 1'b0;
    exp_gap     = 0;
`ifdef CG_CYCLE_COUNT_EN
    busy_cnt    = 0;
`endif
    mon_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", phase, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_seq_err", seq_err, 1'b0);
    chk("rst_iter", iteration, 0);
    chk("rst_a_rd_en", a_rd_en, 1'b0);
    chk("rst_a_rd_addr", a_rd_addr, 0);
    chk("rst_vec_rd_en", vec_rd_en, 4'b0000);
    chk("rst_vec_rd_addr", vec_rd_addr, 0);
    chk("rst_vec_wr_en", vec_wr_en, 4'b0000);
    chk("rst_vec_wr_addr", vec_wr_addr, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();
    chk("idle_phase", phase, 3'd0);

    // First solve: converges in the third iteration.
    do_start();
    run_iter(1'b0, 1'b0);
    run_iter(1'b0, 1'b0);
    run_iter(1'b1, 1'b0);
    tick();
    tick();
    chk("halt_hold_phase", phase, 3'd5);
    chk("halt_hold_flag", halt, 1'b1);
    chk("halt_hold_iter", iteration, 3);
`ifdef CG_CYCLE_COUNT_EN
    chk("cycle_count_conv", cycle_count, busy_cnt);
`endif

    // Second solve: never converges, stall at A address 5 in the first iteration.
    do_start();
    run_iter(1'b0, 1'b1);
    for (int i = 1; i < 20; i++) run_iter(1'b0, 1'b0);
    tick();
    chk("maxit_phase", phase, 3'd5);
    chk("maxit_iter", iteration, 20);
    chk("maxit_busy", busy, 1'b0);
`ifdef CG_CYCLE_COUNT_EN
    chk("cycle_count_max", cycle_count, busy_cnt);
`endif

    // Third solve: illegal writes in MXV, then reset while in DOT.
    do_start();
    do_mxv(1'b0, 1'b1);
    scalar_done = 1'b1;
    tick();
    scalar_done = 1'b0;
    chk("pre_rst_phase", phase, 3'd2);
    chk("pre_rst_rd_en", vec_rd_en, 4'b1110);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("midrst_phase", phase, 3'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_seq_err", seq_err, 1'b0);
    chk("midrst_iter", iteration, 0);
    chk("midrst_vec_rd_en", vec_rd_en, 4'b0000);
    chk("midrst_vec_rd_addr", vec_rd_addr, 0);
    chk("midrst_a_rd_en", a_rd_en, 1'b0);
    chk("midrst_a_rd_addr", a_rd_addr, 0);
    tick();
    reset       = 1'b0;
    exp_seq_err = 1'b0;
    mon_clear();
    mon_en = 1'b1;
    tick();
    do_start();
    run_iter(1'b0, 1'b0);
    chk("post_rst_seq_err", seq_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
